// File: rtl/sat_arith_pkg.sv
// Shared saturating-arithmetic definitions for the signed datapath.
//   DATAW_DEFAULT : default two's-complement datapath width
//   sat_max/min   : largest/smallest representable value for a given width
//   sat_clamp     : fold a DATAW_DEFAULT+1 bit result into DATAW_DEFAULT bits plus a clamp flag
package sat_arith_pkg;

    localparam int unsigned DATAW_DEFAULT = 8;

    typedef struct packed {
        logic                            sat;
        logic signed [DATAW_DEFAULT-1:0] val;
    } sat_res_t;

    function automatic int sat_max(input int unsigned width);
        return (1 << (width - 1)) - 1;
    endfunction

    function automatic int sat_min(input int unsigned width);
        return -(1 << (width - 1));
    endfunction

    // Overflow iff the two top bits of the widened result disagree; the sign bit of the
    // widened result then tells which rail to clamp to.
    function automatic sat_res_t sat_clamp(input logic signed [DATAW_DEFAULT:0] x);
        sat_res_t r;
        r.sat = x[DATAW_DEFAULT] ^ x[DATAW_DEFAULT-1];
        r.val = x[DATAW_DEFAULT-1:0];
        if (r.sat) begin
            r.val = x[DATAW_DEFAULT] ? DATAW_DEFAULT'(sat_min(DATAW_DEFAULT))
                                     : DATAW_DEFAULT'(sat_max(DATAW_DEFAULT));
        end
        return r;
    endfunction

endpackage

// File: rtl/sat_sub_accumulator_if.sv
// Operand/result stream bundle for sat_sub_accumulator.
// Signal names carry the direction as seen from the accumulator.
//   in_valid_i/in_ready_o, dataa_i, datab_i, last_i : operand stream
//   out_valid_o/out_ready_i, diff_o, acc_o, last_o, sat_o : result stream
// slave  : accumulator side
// master : producer/consumer side
interface sat_sub_accumulator_if
    import sat_arith_pkg::*;
#(
    parameter int unsigned DATAW = DATAW_DEFAULT
) ();

    logic                    in_valid_i;
    logic                    in_ready_o;
    logic signed [DATAW-1:0] dataa_i;
    logic signed [DATAW-1:0] datab_i;
    logic                    last_i;
    logic                    out_valid_o;
    logic                    out_ready_i;
    logic signed [DATAW-1:0] diff_o;
    logic signed [DATAW-1:0] acc_o;
    logic                    last_o;
    logic                    sat_o;

    modport slave (
        input  in_valid_i, dataa_i, datab_i, last_i, out_ready_i,
        output in_ready_o, out_valid_o, diff_o, acc_o, last_o, sat_o
    );

    modport master (
        output in_valid_i, dataa_i, datab_i, last_i, out_ready_i,
        input  in_ready_o, out_valid_o, diff_o, acc_o, last_o, sat_o
    );

endinterface

// File: rtl/adder.sv
// Combinational saturating signed adder.
//   dataa_i, datab_i : signed addends
//   sum_o            : sat(a + b)
//   sat_o            : result was clamped
module adder
    import sat_arith_pkg::*;
#(
    parameter int unsigned DATAW = DATAW_DEFAULT
) (
    input  logic signed [DATAW-1:0] dataa_i,
    input  logic signed [DATAW-1:0] datab_i,
    output logic signed [DATAW-1:0] sum_o,
    output logic                    sat_o
);

    localparam logic signed [DATAW-1:0] SatMax = DATAW'(sat_max(DATAW));
    localparam logic signed [DATAW-1:0] SatMin = DATAW'(sat_min(DATAW));

    logic signed [DATAW:0] wide;

    always_comb begin
        wide  = {dataa_i[DATAW-1], dataa_i} + {datab_i[DATAW-1], datab_i};
        sat_o = wide[DATAW] ^ wide[DATAW-1];
        sum_o = wide[DATAW-1:0];
        if (sat_o) begin
            sum_o = wide[DATAW] ? SatMin : SatMax;
        end
    end

endmodule

// File: rtl/subtractor.sv
// Combinational saturating signed subtractor, counterpart of adder.
//   dataa_i : signed minuend
//   datab_i : signed subtrahend
//   diff_o  : sat(a - b)
//   sat_o   : result was clamped
module subtractor
    import sat_arith_pkg::*;
#(
    parameter int unsigned DATAW = DATAW_DEFAULT
) (
    input  logic signed [DATAW-1:0] dataa_i,
    input  logic signed [DATAW-1:0] datab_i,
    output logic signed [DATAW-1:0] diff_o,
    output logic                    sat_o
);

    localparam logic signed [DATAW-1:0] SatMax = DATAW'(sat_max(DATAW));
    localparam logic signed [DATAW-1:0] SatMin = DATAW'(sat_min(DATAW));

    logic signed [DATAW:0] wide;

    always_comb begin
        wide   = {dataa_i[DATAW-1], dataa_i} - {datab_i[DATAW-1], datab_i};
        sat_o  = wide[DATAW] ^ wide[DATAW-1];
        diff_o = wide[DATAW-1:0];
        if (sat_o) begin
            diff_o = wide[DATAW] ? SatMin : SatMax;
        end
    end

endmodule

// File: rtl/sat_sub_accumulator.sv
// Two-stage valid/ready saturating subtract-accumulate pipeline.
//   clk_i  : clock, all state on rising edge
//   rst_ni : synchronous active-low reset
//   bus    : operand stream in (a, b, last) and result stream out
//            (diff = sat(a-b), acc = running saturated group sum, last echo, sat flag)
// S1 holds the saturated difference; S2 holds the element's final result. The running
// accumulator advances only when an element moves S1 -> S2 and clears after a last element.
module sat_sub_accumulator
    import sat_arith_pkg::*;
#(
    parameter int unsigned DATAW = DATAW_DEFAULT
) (
    input logic                 clk_i,
    input logic                 rst_ni,
    sat_sub_accumulator_if.slave bus
);

    logic                    s1_valid_q, s1_valid_d;
    logic signed [DATAW-1:0] s1_diff_q, s1_diff_d;
    logic                    s1_sat_q, s1_sat_d;
    logic                    s1_last_q, s1_last_d;

    logic                    s2_valid_q, s2_valid_d;
    logic signed [DATAW-1:0] s2_diff_q, s2_diff_d;
    logic signed [DATAW-1:0] s2_acc_q, s2_acc_d;
    logic                    s2_sat_q, s2_sat_d;
    logic                    s2_last_q, s2_last_d;

    logic signed [DATAW-1:0] acc_q, acc_d;

    logic signed [DATAW-1:0] sub_diff;
    logic                    sub_sat;
    logic signed [DATAW-1:0] acc_next;
    logic                    acc_sat;

    logic s2_adv, s1_adv, in_ready, in_fire, s1_fire;

    subtractor #(
        .DATAW(DATAW)
    ) u_subtractor (
        .dataa_i(bus.dataa_i),
        .datab_i(bus.datab_i),
        .diff_o (sub_diff),
        .sat_o  (sub_sat)
    );

    adder #(
        .DATAW(DATAW)
    ) u_adder (
        .dataa_i(acc_q),
        .datab_i(s1_diff_q),
        .sum_o  (acc_next),
        .sat_o  (acc_sat)
    );

    always_comb begin
        s2_adv   = !s2_valid_q | bus.out_ready_i;
        s1_adv   = !s1_valid_q | s2_adv;
        // Held low during reset so nothing is accepted into a pipeline being cleared.
        in_ready = rst_ni & s1_adv;
        in_fire  = bus.in_valid_i & in_ready;
        s1_fire  = s1_valid_q & s2_adv;

        s1_valid_d = s1_valid_q;
        s1_diff_d  = s1_diff_q;
        s1_sat_d   = s1_sat_q;
        s1_last_d  = s1_last_q;
        s2_valid_d = s2_valid_q;
        s2_diff_d  = s2_diff_q;
        s2_acc_d   = s2_acc_q;
        s2_sat_d   = s2_sat_q;
        s2_last_d  = s2_last_q;
        acc_d      = acc_q;

        // A stage that may advance either refills or empties; data only loads on transfer.
        if (s1_adv) begin
            s1_valid_d = in_fire;
        end
        if (in_fire) begin
            s1_diff_d = sub_diff;
            s1_sat_d  = sub_sat;
            s1_last_d = bus.last_i;
        end

        if (s2_adv) begin
            s2_valid_d = s1_valid_q;
        end
        if (s1_fire) begin
            s2_diff_d = s1_diff_q;
            s2_acc_d  = acc_next;
            s2_sat_d  = s1_sat_q | acc_sat;
            s2_last_d = s1_last_q;
            acc_d     = s1_last_q ? '0 : acc_next;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            s1_valid_q <= 1'b0;
            s1_diff_q  <= '0;
            s1_sat_q   <= 1'b0;
            s1_last_q  <= 1'b0;
            s2_valid_q <= 1'b0;
            s2_diff_q  <= '0;
            s2_acc_q   <= '0;
            s2_sat_q   <= 1'b0;
            s2_last_q  <= 1'b0;
            acc_q      <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_diff_q  <= s1_diff_d;
            s1_sat_q   <= s1_sat_d;
            s1_last_q  <= s1_last_d;
            s2_valid_q <= s2_valid_d;
            s2_diff_q  <= s2_diff_d;
            s2_acc_q   <= s2_acc_d;
            s2_sat_q   <= s2_sat_d;
            s2_last_q  <= s2_last_d;
            acc_q      <= acc_d;
        end
    end

    assign bus.in_ready_o  = in_ready;
    assign bus.out_valid_o = s2_valid_q;
    assign bus.diff_o      = s2_diff_q;
    assign bus.acc_o       = s2_acc_q;
    assign bus.last_o      = s2_last_q;
    assign bus.sat_o       = s2_sat_q;

endmodule

// File: tb/tb_sat_sub_accumulator.sv
// Directed + randomized bench for sat_sub_accumulator with a queue-based reference model.
module tb_sat_sub_accumulator;

    localparam int unsigned W = 8;
    localparam int HI = (1 << (W - 1)) - 1;
    localparam int LO = -(1 << (W - 1));

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    sat_sub_accumulator_if #(.DATAW(W)) bus ();

    sat_sub_accumulator #(
        .DATAW(W)
    ) dut (
        .clk_i (clk),
        .rst_ni(rst_n),
        .bus   (bus)
    );

    typedef struct {
        int diff;
        int acc;
        bit sat;
        bit last;
    } exp_t;

    exp_t q[$];
    int   racc = 0;
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   out_cnt = 0;
    int   first_out_cyc = -1;
    int   last_out_cyc = -1;
    bit   accepted;
    bit   prev_stall = 0;
    logic [W-1:0] prev_diff, prev_acc;
    logic prev_sat, prev_last;

    function automatic int clampw(input int x);
        if (x > HI) return HI;
        if (x < LO) return LO;
        return x;
    endfunction

    function automatic logic [31:0] sx(input logic [W-1:0] v);
        return {{(32 - W){v[W-1]}}, v};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, $signed(obs), $signed(exp));
        end
    endtask

    // Sample the current cycle (after inputs settle), then advance to the next negedge.
    task automatic step();
        exp_t e;
        int   a, b, dr, ar;
        #1;
        accepted = 0;
        if (rst_n !== 1'b1) begin
            q.delete();
            racc       = 0;
            prev_stall = 0;
        end else begin
            if (prev_stall) begin
                check("stall_valid", bus.out_valid_o, 1);
                check("stall_diff", sx(bus.diff_o), sx(prev_diff));
                check("stall_acc", sx(bus.acc_o), sx(prev_acc));
                check("stall_sat", bus.sat_o, prev_sat);
                check("stall_last", bus.last_o, prev_last);
            end
            if (bus.out_valid_o === 1'b1 && bus.out_ready_i) begin
                out_cnt++;
                last_out_cyc = cyc;
                if (first_out_cyc < 0) first_out_cyc = cyc;
                check("out_expected", q.size() > 0, 1);
                if (q.size() > 0) begin
                    e = q.pop_front();
                    check("diff", sx(bus.diff_o), e.diff);
                    check("acc", sx(bus.acc_o), e.acc);
                    check("sat", bus.sat_o, e.sat);
                    check("last", bus.last_o, e.last);
                end
            end
            prev_stall = (bus.out_valid_o === 1'b1) && !bus.out_ready_i;
            prev_diff  = bus.diff_o;
            prev_acc   = bus.acc_o;
            prev_sat   = bus.sat_o;
            prev_last  = bus.last_o;
            if (bus.in_valid_i && bus.in_ready_o === 1'b1) begin
                a      = int'(bus.dataa_i);
                b      = int'(bus.datab_i);
                dr     = a - b;
                e.diff = clampw(dr);
                ar     = racc + e.diff;
                e.acc  = clampw(ar);
                e.sat  = (e.diff != dr) || (e.acc != ar);
                e.last = bus.last_i;
                racc   = e.last ? 0 : e.acc;
                q.push_back(e);
                accepted = 1;
            end
        end
        @(negedge clk);
        cyc++;
    endtask

    task automatic send(input int a, input int b, input bit last);
        bit got = 0;
        bus.in_valid_i = 1'b1;
        bus.dataa_i    = W'(a);
        bus.datab_i    = W'(b);
        bus.last_i     = last;
        for (int i = 0; i < 50; i++) begin
            step();
            if (accepted) begin
                got = 1;
                break;
            end
        end
        if (!got) check("send_timeout", 0, 1);
        bus.in_valid_i = 1'b0;
    endtask

    task automatic drain(input int n);
        bus.in_valid_i = 1'b0;
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        int pa[4] = '{11, -20, 33, -44};
        int pb[4] = '{1, 2, 3, 4};
        int idx, c0, start;

        rst_n           = 1'b0;
        bus.in_valid_i  = 1'b0;
        bus.dataa_i     = '0;
        bus.datab_i     = '0;
        bus.last_i      = 1'b0;
        bus.out_ready_i = 1'b1;
        step();
        step();
        check("rst_out_valid", bus.out_valid_o, 0);
        check("rst_diff", sx(bus.diff_o), 0);
        check("rst_acc", sx(bus.acc_o), 0);
        check("rst_last", bus.last_o, 0);
        check("rst_sat", bus.sat_o, 0);
        check("rst_in_ready", bus.in_ready_o, 0);
        rst_n = 1'b1;
        #1;
        check("post_rst_in_ready", bus.in_ready_o, 1);

        // Single element latency and one-cycle output pulse.
        send(5, 3, 1);
        check("lat_s1_only", bus.out_valid_o, 0);
        step();
        check("lat_valid", bus.out_valid_o, 1);
        check("lat_diff", sx(bus.diff_o), 2);
        check("lat_acc", sx(bus.acc_o), 2);
        check("lat_sat", bus.sat_o, 0);
        check("lat_last", bus.last_o, 1);
        step();
        check("lat_pulse_end", bus.out_valid_o, 0);

        // Subtraction clamp corners.
        send(-128, 1, 1);
        send(127, -1, 1);
        send(-1, -1, 1);
        // Accumulator clamp on both rails, then a fresh group.
        send(100, 0, 0);
        send(100, 0, 0);
        send(0, 10, 1);
        send(4, 1, 1);
        send(-100, 27, 0);
        send(-100, 100, 1);
        drain(4);

        // Back-pressure: only two elements fit.
        bus.out_ready_i = 1'b0;
        idx = 0;
        for (int i = 0; i < 5; i++) begin
            bus.in_valid_i = 1'b1;
            bus.dataa_i    = W'(pa[idx]);
            bus.datab_i    = W'(pb[idx]);
            bus.last_i     = 1'b0;
            step();
            if (accepted) idx++;
        end
        bus.in_valid_i = 1'b0;
        check("stall_accepts", idx, 2);
        check("stall_in_ready", bus.in_ready_o, 0);
        bus.out_ready_i = 1'b1;
        c0 = out_cnt;
        drain(4);
        check("stall_release_cnt", out_cnt - c0, 2);
        send(pa[2], pb[2], 0);
        send(pa[3], pb[3], 1);
        drain(4);

        // Back-to-back burst.
        c0            = out_cnt;
        first_out_cyc = -1;
        start         = cyc;
        for (int i = 0; i < 16; i++) begin
            send(int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 255)) - 128,
                 (i == 15) || ($urandom_range(0, 3) == 0));
        end
        check("burst_accept_cycles", cyc - start, 16);
        drain(4);
        check("burst_out_cnt", out_cnt - c0, 16);
        check("burst_first_lat", first_out_cyc - start, 2);
        check("burst_contiguous", last_out_cyc - first_out_cyc, 15);

        // Random valid/ready traffic.
        for (int i = 0; i < 60; i++) begin
            bus.in_valid_i  = 1'($urandom_range(0, 1));
            bus.dataa_i     = W'($urandom);
            bus.datab_i     = W'($urandom);
            bus.last_i      = ($urandom_range(0, 4) == 0);
            bus.out_ready_i = ($urandom_range(0, 2) != 0);
            step();
        end
        bus.out_ready_i = 1'b1;
        drain(5);
        check("random_drained", q.size(), 0);

        // Reset with both stages full.
        bus.out_ready_i = 1'b0;
        send(50, 0, 0);
        send(60, 0, 0);
        check("full_before_rst", bus.out_valid_o, 1);
        check("full_in_ready", bus.in_ready_o, 0);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check("mid_rst_valid", bus.out_valid_o, 0);
        check("mid_rst_diff", sx(bus.diff_o), 0);
        check("mid_rst_acc", sx(bus.acc_o), 0);
        check("mid_rst_sat", bus.sat_o, 0);
        check("mid_rst_last", bus.last_o, 0);
        bus.out_ready_i = 1'b1;
        send(7, 2, 0);
        step();
        check("after_rst_acc", sx(bus.acc_o), 5);
        drain(3);
        check("final_drained", q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
